pipe_stage_reg: RTL and testbench

//   Parametrised pipeline stage register: the generic successor to the

---
 rtl/pipe_stage_reg.sv | 136 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshakes.
// Optional 2-entry skid buffer and saturating back-pressure counter.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic in_fire;
  logic out_fire;
  logic stall_now;
  logic do_flush;

  // Handshake terms; with the skid buffer in_ready is a pure register decode
  always_comb begin
    out_valid = (state_q != S_EMPTY);
    if (SKID != 0) begin
      in_ready = en & (state_q != S_TWO);
    end else begin
      in_ready = en & (~out_valid | out_ready);
    end
    in_fire   = en & in_valid & in_ready;
    out_fire  = en & out_valid & out_ready;
    stall_now = en & out_valid & ~out_ready;
    do_flush  = en & flush;
  end

  // Head entry drives the outputs; control reads as a bubble when empty
  always_comb begin
    out_data  = main_data_q;
    out_ctrl  = out_valid ? main_ctrl_q : '0;
    stall_cnt = stall_q;
  end

  // Occupancy FSM: main holds the head, skid holds the entry behind it
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    unique case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          state_d     = S_ONE;
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end else if (in_fire) begin
          state_d     = S_TWO;
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
        end
      end
      S_TWO: begin
        if (out_fire) begin
          state_d     = S_ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
    // Flush drops everything held plus any entry arriving this cycle
    if (do_flush) begin
      state_d     = S_EMPTY;
      main_data_d = '0;
      main_ctrl_d = '0;
      skid_data_d = '0;
      skid_ctrl_d = '0;
    end
  end

  // Back-pressure counter saturates instead of wrapping; flush leaves it
  always_comb begin
    stall_d = stall_q;
    if (stall_now && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // State registers; en=0 leaves every _d equal to its _q
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_q     <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed table on a skid instance, plus
// random traffic on skid, no-skid and narrow-counter instances vs a FIFO model.
module tb_pipe_stage_reg;

  logic        CLK = 1'b0;
  logic        RST;
  logic        en;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;
  logic        out_ready;

  logic        ir_w [3];
  logic        ov_w [3];
  logic [31:0] od_w [3];
  logic [15:0] oc_w [3];
  logic [15:0] sc_w [3];
  logic [15:0] sc_a;
  logic [15:0] sc_b;
  logic [1:0]  sc_c;

  assign sc_w[0] = sc_a;
  assign sc_w[1] = sc_b;
  assign sc_w[2] = {14'b0, sc_c};

  always #5 CLK = ~CLK;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_w[0]),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov_w[0]), .out_ready(out_ready),
    .out_data(od_w[0]), .out_ctrl(oc_w[0]), .stall_cnt(sc_a)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(0), .CNT_W(16)) dut_b (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_w[1]),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov_w[1]), .out_ready(out_ready),
    .out_data(od_w[1]), .out_ctrl(oc_w[1]), .stall_cnt(sc_b)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CNT_W(2)) dut_c (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_w[2]),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov_w[2]), .out_ready(out_ready),
    .out_data(od_w[2]), .out_ctrl(oc_w[2]), .stall_cnt(sc_c)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of capacity 1 or 2 per instance
  string       nm   [3] = '{"a", "b", "c"};
  int          cap  [3] = '{2, 1, 2};
  int          smax [3] = '{65535, 65535, 3};
  logic [47:0] mfifo[3][2];
  int          mcnt [3] = '{0, 0, 0};
  logic [31:0] mlast[3] = '{32'h0, 32'h0, 32'h0};
  int          mstall[3] = '{0, 0, 0};

  function automatic logic m_ready(input int i);
    if (!en) return 1'b0;
    if (cap[i] == 2) return mcnt[i] < 2;
    return (mcnt[i] == 0) || out_ready;
  endfunction

  task automatic model_check();
    for (int i = 0; i < 3; i++) begin
      logic        eov;
      logic [31:0] eod;
      logic [15:0] eoc;
      eov = (mcnt[i] != 0);
      eod = eov ? mfifo[i][0][47:16] : mlast[i];
      eoc = eov ? mfifo[i][0][15:0] : 16'h0;
      chk({nm[i], ".in_ready"},  32'(ir_w[i]), 32'(m_ready(i)));
      chk({nm[i], ".out_valid"}, 32'(ov_w[i]), 32'(eov));
      chk({nm[i], ".out_data"},  od_w[i], eod);
      chk({nm[i], ".out_ctrl"},  32'(oc_w[i]), 32'(eoc));
      chk({nm[i], ".stall_cnt"}, 32'(sc_w[i]), 32'(mstall[i]));
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      logic rdy;
      logic ofire;
      logic ifire;
      rdy   = m_ready(i);
      ofire = (mcnt[i] > 0) && out_ready;
      ifire = in_valid && rdy;
      if (RST) begin
        mcnt[i]   = 0;
        mlast[i]  = 32'h0;
        mstall[i] = 0;
      end else if (en) begin
        if (mcnt[i] > 0 && !out_ready && mstall[i] < smax[i])
          mstall[i]++;
        if (flush) begin
          mcnt[i]  = 0;
          mlast[i] = 32'h0;
        end else begin
          if (ofire) begin
            mlast[i]    = mfifo[i][0][47:16];
            mfifo[i][0] = mfifo[i][1];
            mcnt[i]--;
          end
          if (ifire) begin
            mfifo[i][mcnt[i]] = {in_data, in_ctrl};
            mcnt[i]++;
          end
        end
      end
    end
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        eov;
    logic [31:0] eod;
    logic [15:0] eoc;
    logic        eir;
    logic [15:0] esc;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic e, input logic fl, input logic iv,
    input logic [31:0] d, input logic ordy, input logic eov,
    input logic [31:0] eod, input logic [15:0] eoc,
    input logic eir, input logic [15:0] esc);
    vec_t v;
    v.rst = rst; v.en = e; v.fl = fl; v.iv = iv; v.d = d;
    v.ordy = ordy; v.eov = eov; v.eod = eod; v.eoc = eoc;
    v.eir = eir; v.esc = esc;
    return v;
  endfunction

  vec_t tv[23];

  task automatic drive(input vec_t v);
    RST       = v.rst;
    en        = v.en;
    flush     = v.fl;
    in_valid  = v.iv;
    in_data   = v.d;
    in_ctrl   = v.d[15:0];
    out_ready = v.ordy;
  endtask

  task automatic tick();
    @(negedge CLK);
    model_check();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // rst en fl iv data ordy | ov odata octrl ir stall (instance a)
    tv[0]  = mk(1,1,0,1,32'hDEAD_BEEF,1, 0,32'h0, 16'h0, 1,0);
    tv[1]  = mk(0,1,0,1,32'h1, 1, 0,32'h0, 16'h0, 1,0);
    tv[2]  = mk(0,1,0,1,32'h2, 1, 1,32'h1, 16'h1, 1,0);
    tv[3]  = mk(0,1,0,1,32'h3, 1, 1,32'h2, 16'h2, 1,0);
    tv[4]  = mk(0,1,0,0,32'h0, 1, 1,32'h3, 16'h3, 1,0);
    tv[5]  = mk(0,1,0,0,32'h0, 0, 0,32'h3, 16'h0, 1,0);
    tv[6]  = mk(0,1,0,1,32'hA, 0, 0,32'h3, 16'h0, 1,0);
    tv[7]  = mk(0,1,0,1,32'hB, 0, 1,32'hA, 16'hA, 1,0);
    tv[8]  = mk(0,1,0,1,32'hC, 0, 1,32'hA, 16'hA, 0,1);
    tv[9]  = mk(0,1,0,1,32'hC, 0, 1,32'hA, 16'hA, 0,2);
    tv[10] = mk(0,1,0,1,32'hC, 1, 1,32'hA, 16'hA, 0,3);
    tv[11] = mk(0,1,0,1,32'hC, 1, 1,32'hB, 16'hB, 1,3);
    tv[12] = mk(0,1,0,0,32'h0, 1, 1,32'hC, 16'hC, 1,3);
    tv[13] = mk(0,1,0,1,32'h55,0, 0,32'hC, 16'h0, 1,3);
    tv[14] = mk(0,0,1,1,32'h66,0, 1,32'h55,16'h55,0,3);
    tv[15] = mk(0,0,1,1,32'h66,0, 1,32'h55,16'h55,0,3);
    tv[16] = mk(0,0,1,1,32'h66,0, 1,32'h55,16'h55,0,3);
    tv[17] = mk(0,1,0,0,32'h0, 1, 1,32'h55,16'h55,1,3);
    tv[18] = mk(0,1,0,1,32'h70,0, 0,32'h55,16'h0, 1,3);
    tv[19] = mk(0,1,0,1,32'h71,0, 1,32'h70,16'h70,1,3);
    tv[20] = mk(0,1,1,1,32'h77,0, 1,32'h70,16'h70,0,4);
    tv[21] = mk(0,1,0,0,32'h0, 1, 0,32'h0, 16'h0, 1,5);
    tv[22] = mk(0,1,0,0,32'h0, 1, 0,32'h0, 16'h0, 1,5);

    // First reset edge; register contents are unknown before it
    drive(tv[0]);
    @(posedge CLK);
    #1;

    for (int r = 0; r < 23; r++) begin
      drive(tv[r]);
      @(negedge CLK);
      chk($sformatf("vec%0d.out_valid", r), 32'(ov_w[0]), 32'(tv[r].eov));
      chk($sformatf("vec%0d.out_data", r),  od_w[0], tv[r].eod);
      chk($sformatf("vec%0d.out_ctrl", r),  32'(oc_w[0]), 32'(tv[r].eoc));
      chk($sformatf("vec%0d.in_ready", r),  32'(ir_w[0]), 32'(tv[r].eir));
      chk($sformatf("vec%0d.stall_cnt", r), 32'(sc_a), 32'(tv[r].esc));
      model_check();
      model_step();
      @(posedge CLK);
      #1;
    end

    // Narrow counter pinned at its ceiling through the flush
    chk("c.stall_sat_after_flush", 32'(sc_c), 32'd3);

    // No-skid stage under back-pressure never takes a second entry
    RST = 1'b0; en = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1234_5678; in_ctrl = 16'h5678;
    tick();
    in_data = 32'h9ABC_DEF0; in_ctrl = 16'hDEF0;
    @(negedge CLK);
    chk("b.in_ready_full", 32'(ir_w[1]), 32'd0);
    chk("b.head_kept", od_w[1], 32'h1234_5678);
    model_check();
    model_step();
    @(posedge CLK);
    #1;

    // Randomised traffic against the FIFO model
    RST = 1'b1;
    tick();
    for (int n = 0; n < 3000; n++) begin
      RST       = ($urandom_range(0, 299) == 0);
      en        = ($urandom_range(0, 9) < 8);
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = ($urandom_range(0, 9) < 6);
      in_data   = $urandom;
      in_ctrl   = 16'($urandom);
      out_ready = ((n / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                      : ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
